adder_scheduler: RTL and testbench
==================================

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 Parameter SLICE_W, 16, width of the shared prefix-adder slice; the operand width is fixed at 2*SLICE_W = 32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
REQ-006 req0_a, req0_b  in  32 each  operands; narrow ops use [15:0] only.
REQ-007 req0_wide  in  1  1 = 32-bit add (two slice passes), 0 = 16-bit add.
REQ-008 req0_cin  in  1  carry-in to the low slice.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_wide, req1_cin: same as REQ-004..008 for requester 1.
REQ-010 rsp_valid  out  1  result available; held until rsp_ready.
REQ-011 rsp_ready  in  1  consumer takes result when valid&ready.
REQ-012 rsp_id  out  1  index of the requester that owns the result.
REQ-013 rsp_sum  out  32  sum; [31:16] = 0 for narrow ops.
REQ-014 rsp_cout  out  1  carry out of the final slice pass (bit 16 narrow, bit 32 wide).

Function
REQ-015 FSM states IDLE, LO, HI, DONE; exactly one 16-bit adder slice is shared by all passes.
REQ-016 In IDLE, a round-robin arbiter SHALL grant one valid requester: if both valid, grant the one not granted last; if one valid, grant it.
REQ-017 reqN_ready SHALL be high only in IDLE for the granted requester; both readys low in LO, HI, DONE.
REQ-018 On accept, operands, wide, cin and id SHALL be captured; later input changes have no effect on the operation.
REQ-019 IDLE -> LO on accept; LO computes a[15:0]+b[15:0]+cin, registers low sum and carry.
REQ-020 LO -> DONE if narrow; LO -> HI if wide; HI computes a[31:16]+b[31:16]+registered low carry, registers high sum and carry.
REQ-021 HI -> DONE; DONE -> IDLE on rsp_valid&rsp_ready; otherwise hold DONE with rsp_* stable.
REQ-022 rsp_valid SHALL be high exactly in DONE; latency accept-edge to rsp_valid: narrow 2 cycles, wide 3 cycles.
REQ-023 A new grant SHALL NOT occur in the cycle the response is consumed; minimum one IDLE cycle between operations.
REQ-024 Sum arithmetic is modulo 2^16 per slice; carry propagates only from LO to HI, never wraps back.

Reset
REQ-025 rst SHALL force state IDLE, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, both readys 0 while asserted, last-grant = 1 (req0 wins the first tie).
REQ-026 Reset mid-operation SHALL discard the in-flight operation; no response is produced for it.

Structure
REQ-027 Package adder_sched_pkg SHALL hold SLICE_W, the FSM state enum and the requester-id type.
REQ-028 One sub-module prefix_add16 (16-bit parallel prefix adder with cin, sum, cout) SHALL be instantiated once; the block contains no other adder.

Verification
REQ-029 req0 narrow a=0x0000FFFF b=0x00000001 cin=0 -> rsp_sum=0x00000000, rsp_cout=1, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-030 req1 wide a=0x0000FFFF b=0x00000001 cin=0 -> rsp_sum=0x00010000, rsp_cout=0, rsp_id=1, rsp_valid 3 cycles after accept.
REQ-031 req0 wide a=0xFFFFFFFF b=0x00000000 cin=1 -> rsp_sum=0x00000000, rsp_cout=1.
REQ-032 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-033 rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_sum, rsp_id stable; req0_ready=req1_ready=0 throughout.
REQ-034 rst asserted during HI -> rsp_valid=0 immediately, no response for that op; next tie granted to req0.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder scheduler: slice width, FSM state
// encoding, requester id type and the round-robin pick rule.
package adder_sched_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic req_id_t;

    // Last-grant value after reset, so requester 0 wins the first tie.
    localparam req_id_t RESET_LAST_GRANT = 1'b1;

    function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t last);
        req_id_t pick;
        if (v0 && v1) begin
            pick = ~last;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/prefix_add16.sv
// Kogge-Stone parallel prefix adder slice with carry-in and carry-out.
// The carry-in is folded into bit 0 so every group generate already includes it.
module prefix_add16
    import adder_sched_pkg::*;
#(
    parameter int W = SLICE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int LVLS = $clog2(W);

    logic [W-1:0] g_lvl [LVLS+1];
    logic [W-1:0] p_lvl [LVLS];
    logic [W:0]   carry;

    always_comb begin
        g_lvl[0]    = a & b;
        p_lvl[0]    = a ^ b;
        g_lvl[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << l)) begin
                    g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i - (1 << l)]);
                    if (l + 1 < LVLS) begin
                        p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i - (1 << l)];
                    end
                end else begin
                    g_lvl[l+1][i] = g_lvl[l][i];
                    if (l + 1 < LVLS) begin
                        p_lvl[l+1][i] = p_lvl[l][i];
                    end
                end
            end
        end
        carry = {g_lvl[LVLS], cin};
        sum   = p_lvl[0] ^ carry[W-1:0];
        cout  = carry[W];
    end

endmodule

// File: rtl/adder_scheduler.sv
// Two-requester add scheduler: round-robin grant, then one shared 16-bit
// prefix adder slice computes the low pass and, for wide ops, the high pass.
module adder_scheduler
    import adder_sched_pkg::*;
#(
    parameter int SLICE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2*SLICE_W-1:0] req0_a,
    input  logic [2*SLICE_W-1:0] req0_b,
    input  logic                 req0_wide,
    input  logic                 req0_cin,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2*SLICE_W-1:0] req1_a,
    input  logic [2*SLICE_W-1:0] req1_b,
    input  logic                 req1_wide,
    input  logic                 req1_cin,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*SLICE_W-1:0] rsp_sum,
    output logic                 rsp_cout
);

    state_e                state;
    req_id_t               last_grant;
    req_id_t               grant_id;
    logic                  grant;

    logic [2*SLICE_W-1:0]  op_a;
    logic [2*SLICE_W-1:0]  op_b;
    logic                  op_wide;
    logic                  op_cin;
    logic                  lo_carry;

    logic [SLICE_W-1:0]    add_a;
    logic [SLICE_W-1:0]    add_b;
    logic                  add_cin;
    logic [SLICE_W-1:0]    add_sum;
    logic                  add_cout;

    // Readys are held low while rst is asserted even though state is already IDLE.
    always_comb begin
        grant_id   = rr_pick(req0_valid, req1_valid, last_grant);
        grant      = (state == ST_IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = grant && (grant_id == 1'b0);
        req1_ready = grant && (grant_id == 1'b1);
    end

    assign rsp_valid = (state == ST_DONE);

    // NOTE: every branch assigns every mux output, so no latch is inferred.
    always_comb begin
        if (state == ST_HI) begin
            add_a   = op_a[2*SLICE_W-1:SLICE_W];
            add_b   = op_b[2*SLICE_W-1:SLICE_W];
            add_cin = lo_carry;
        end else begin
            add_a   = op_a[SLICE_W-1:0];
            add_b   = op_b[SLICE_W-1:0];
            add_cin = op_cin;
        end
    end

    prefix_add16 #(
        .W   (SLICE_W)
    ) u_slice (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= RESET_LAST_GRANT;
            op_a       <= '0;
            op_b       <= '0;
            op_wide    <= 1'b0;
            op_cin     <= 1'b0;
            lo_carry   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        op_a       <= grant_id ? req1_a    : req0_a;
                        op_b       <= grant_id ? req1_b    : req0_b;
                        op_wide    <= grant_id ? req1_wide : req0_wide;
                        op_cin     <= grant_id ? req1_cin  : req0_cin;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_LO;
                    end
                end
                ST_LO: begin
                    rsp_sum  <= {{SLICE_W{1'b0}}, add_sum};
                    rsp_cout <= add_cout;
                    lo_carry <= add_cout;
                    state    <= op_wide ? ST_HI : ST_DONE;
                end
                ST_HI: begin
                    rsp_sum[2*SLICE_W-1:SLICE_W] <= add_sum;
                    rsp_cout                     <= add_cout;
                    state                        <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_scheduler.sv
// Scoreboard bench for adder_scheduler: directed cases, round-robin tie run,
// randomized traffic and reset during the high pass.
module tb_adder_scheduler;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_wide, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_wide, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0] rsp_sum;

    always #5 clk = ~clk;

    adder_scheduler #(.SLICE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_wide (req0_wide),
        .req0_cin  (req0_cin),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_wide (req1_wide),
        .req1_cin  (req1_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic [31:0] sum;
        logic        cout;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    logic model_last = 1'b1;
    int   grant_log[$];
    logic [1:0] mon_exp_rdy;
    logic       mon_exp_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting on DUT (cycle %0d)", name, cyc);
    endtask

    // Reference: a narrow op is a 17-bit add of the low halves, a wide op a 33-bit add.
    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic wide, input logic cin, input int now);
        exp_t        e;
        logic [32:0] full;
        logic [16:0] nar;
        full = {1'b0, a} + {1'b0, b} + 33'(cin);
        nar  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(cin);
        e.id      = id;
        e.acc_cyc = now;
        if (wide) begin
            e.sum  = full[31:0];
            e.cout = full[32];
            e.lat  = 3;
        end else begin
            e.sum  = {16'h0000, nar[15:0]};
            e.cout = nar[16];
            e.lat  = 2;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        case ($urandom_range(0, 4))
            0:       w = 32'hFFFF_FFFF;
            1:       w = 32'h0000_FFFF;
            2:       w = 32'h0000_0000;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Monitor: checks grant choice, response timing and payload at every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_exp_rdy = 2'b00;
                if (sb.size() == 0) begin
                    if (req0_valid && req1_valid) mon_exp_rdy = model_last ? 2'b01 : 2'b10;
                    else if (req0_valid)          mon_exp_rdy = 2'b01;
                    else if (req1_valid)          mon_exp_rdy = 2'b10;
                end
                check("ready", {req1_ready, req0_ready}, mon_exp_rdy);
                mon_exp_valid = (sb.size() > 0) && ((cyc - sb[0].acc_cyc) >= sb[0].lat);
                check("rsp_valid", rsp_valid, mon_exp_valid);
                if (rsp_valid && mon_exp_valid) begin
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_sum", rsp_sum, sb[0].sum);
                    check("rsp_cout", rsp_cout, sb[0].cout);
                    if (rsp_ready) void'(sb.pop_front());
                end
                if (req0_valid && req0_ready) begin
                    sb.push_back(model(1'b0, req0_a, req0_b, req0_wide, req0_cin, cyc));
                    model_last = 1'b0;
                    grant_log.push_back(0);
                end else if (req1_valid && req1_ready) begin
                    sb.push_back(model(1'b1, req1_a, req1_b, req1_wide, req1_cin, cyc));
                    model_last = 1'b1;
                    grant_log.push_back(1);
                end
            end
        end
    end

    task automatic drive(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic wide, input logic cin);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_wide = wide; req1_cin = cin;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_wide = wide; req0_cin = cin;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        sb.delete();
        model_last = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Issue one op and wait for its response; hold stalls rsp_ready for that many DONE cycles.
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic wide, input logic cin, input int hold,
                         output logic [31:0] o_sum, output logic o_cout, output logic o_id,
                         output int o_lat);
        int  acc_c;
        bit  seen;
        o_sum = 'x; o_cout = 1'bx; o_id = 1'bx; o_lat = -1;
        rsp_ready = (hold == 0);
        drive(id, 1'b1, a, b, wide, cin);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) seen = 1;
        end
        if (!seen) begin
            timeout("accept");
            drive(id, 1'b0, '0, '0, 1'b0, 1'b0);
            return;
        end
        acc_c = cyc;
        @(posedge clk);
        #1;
        drive(id, 1'b0, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        if (!seen) begin
            timeout("rsp_valid");
            rsp_ready = 1'b1;
            return;
        end
        o_lat = cyc - acc_c;
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        o_sum  = rsp_sum;
        o_cout = rsp_cout;
        o_id   = rsp_id;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_sum;
    logic        r_cout, r_id;
    int          r_lat;
    bit          acc0, acc1, got;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b1, 32'h1234_5678, 32'h1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h8765_4321, 32'h1, 1'b0, 1'b1);
        #12;
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_sum", rsp_sum, 32'h0);
        check("rst_rsp_cout", rsp_cout, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        apply_reset();

        do_op(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, r_sum, r_cout, r_id, r_lat);
        check("narrow_sum", r_sum, 32'h0000_0000);
        check("narrow_cout", r_cout, 1'b1);
        check("narrow_id", r_id, 1'b0);
        check("narrow_lat", r_lat, 2);

        do_op(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0, r_sum, r_cout, r_id, r_lat);
        check("wide_sum", r_sum, 32'h0001_0000);
        check("wide_cout", r_cout, 1'b0);
        check("wide_id", r_id, 1'b1);
        check("wide_lat", r_lat, 3);

        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 0, r_sum, r_cout, r_id, r_lat);
        check("wide_cin_sum", r_sum, 32'h0000_0000);
        check("wide_cin_cout", r_cout, 1'b1);

        do_op(1'b1, 32'hABCD_8000, 32'h1111_8000, 1'b0, 1'b1, 5, r_sum, r_cout, r_id, r_lat);
        check("stall_sum", r_sum, 32'h0000_0001);
        check("stall_cout", r_cout, 1'b1);
        check("stall_id", r_id, 1'b1);

        // Both requesters valid continuously: grants alternate starting at 0.
        apply_reset();
        grant_log.delete();
        rsp_ready = 1'b1;
        drive(1'b0, 1'b1, rnd_word(), rnd_word(), $urandom_range(0, 1), $urandom_range(0, 1));
        drive(1'b1, 1'b1, rnd_word(), rnd_word(), $urandom_range(0, 1), $urandom_range(0, 1));
        for (int k = 0; k < 80 && grant_log.size() < 8; k++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0) drive(1'b0, 1'b1, rnd_word(), rnd_word(), $urandom_range(0, 1), $urandom_range(0, 1));
            if (acc1) drive(1'b1, 1'b1, rnd_word(), rnd_word(), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        if (grant_log.size() < 8) timeout("tie_grants");
        for (int i = 0; i < grant_log.size() && i < 8; i++) check("tie_grant", grant_log[i], i % 2);

        // Randomized traffic with random back-pressure.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0 || !req0_valid)
                drive(1'b0, $urandom_range(0, 2) != 0, rnd_word(), rnd_word(), $urandom_range(0, 1), $urandom_range(0, 1));
            if (acc1 || !req1_valid)
                drive(1'b1, $urandom_range(0, 2) != 0, rnd_word(), rnd_word(), $urandom_range(0, 1), $urandom_range(0, 1));
            rsp_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);

        // Reset during the high pass discards the op; next tie goes to req0.
        apply_reset();
        drive(1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req1_valid && req1_ready) got = 1;
        end
        if (!got) timeout("hi_reset_accept");
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("hi_reset_valid", rsp_valid, 1'b0);
        sb.delete();
        model_last = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("hi_reset_no_rsp", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        grant_log.delete();
        drive(1'b0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
        for (int k = 0; k < 10 && grant_log.size() == 0; k++) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        if (grant_log.size() == 0) timeout("post_reset_tie");
        else check("post_reset_tie", grant_log[0], 0);
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
